// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-scan results and shifts each accepted hex digit into a
// 16-bit entry register.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   row[3:0]          keypad rows (active-low, pulled up), row[0] top
//   col[3:0]          keypad column drive (one-hot-low), col[0] leftmost
//   clear             synchronous clear of value
//   key_valid         one-cycle pulse per accepted press
//   key_code[3:0]     hex code of the last accepted key
//   key_down          high while the accepted key is held
//   value[15:0]       entry register, newest digit in [3:0]
module keypad_scanner #(
   parameter int SCAN_DIV       = 2048,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clear,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_down,
   output logic [15:0] value
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Scan timing: slot counter and column drive
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic             slot_last;
   logic             scan_end;

   assign slot_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign scan_end  = slot_last && (col_idx == 2'd3);

   // col is registered rather than decoded from col_idx so the keypad
   // lines never glitch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         col_idx <= 2'd0;
         col     <= 4'b1110;
      end else if (slot_last) begin
         div_cnt <= '0;
         col_idx <= col_idx + 2'd1;
         col     <= {col[2:0], col[3]};
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Row synchronizer and per-column sampling
   // ------------------------------------------------------------------
   logic [3:0] row_meta;
   logic [3:0] row_sync;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_meta <= 4'b1111;
         row_sync <= 4'b1111;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   // Hits for columns 0..2, column-major: bit c*4+r set = row r low while
   // column c was driven. Column 3 is taken straight from row_sync on the
   // scan-end cycle, so it is never stored.
   logic [11:0] hit_acc;
   logic [15:0] hit_now;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_acc <= '0;
      end else if (slot_last) begin
         case (col_idx)
            2'd0:    hit_acc[3:0]  <= ~row_sync;
            2'd1:    hit_acc[7:4]  <= ~row_sync;
            2'd2:    hit_acc[11:8] <= ~row_sync;
            default: ;
         endcase
      end
   end

   assign hit_now = {~row_sync, hit_acc};

   // ------------------------------------------------------------------
   // Scan result classification
   // ------------------------------------------------------------------
   logic [4:0] n_hits;
   logic [3:0] hit_rc;     // {row, col} of the (last) hit found
   logic [3:0] scan_code;
   logic       res_none;
   logic       res_key;

   always_comb begin
      n_hits = 5'd0;
      hit_rc = 4'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (hit_now[c*4 + r]) begin
               n_hits = n_hits + 5'd1;
               hit_rc = {2'(r), 2'(c)};
            end
         end
      end
   end

   always_comb begin
      case (hit_rc)
         4'd0:    scan_code = 4'h1;
         4'd1:    scan_code = 4'h2;
         4'd2:    scan_code = 4'h3;
         4'd3:    scan_code = 4'hA;
         4'd4:    scan_code = 4'h4;
         4'd5:    scan_code = 4'h5;
         4'd6:    scan_code = 4'h6;
         4'd7:    scan_code = 4'hB;
         4'd8:    scan_code = 4'h7;
         4'd9:    scan_code = 4'h8;
         4'd10:   scan_code = 4'h9;
         4'd11:   scan_code = 4'hC;
         4'd12:   scan_code = 4'h0;
         4'd13:   scan_code = 4'hF;
         4'd14:   scan_code = 4'hE;
         default: scan_code = 4'hD;
      endcase
   end

   assign res_none = (n_hits == 5'd0);
   assign res_key  = (n_hits == 5'd1);

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       cand, cand_n;
   logic             accept;
   logic [3:0]       accept_code;
   logic [3:0]       key_code_n;
   logic [15:0]      value_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cand      <= 4'h0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         value     <= 16'h0000;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         key_valid <= accept;
         key_code  <= key_code_n;
         value     <= value_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      accept      = 1'b0;
      accept_code = cand;

      if (scan_end) begin
         case (state)
            IDLE: begin
               if (res_key) begin
                  cand_n = scan_code;
                  cnt_n  = CNT_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept      = 1'b1;
                     accept_code = scan_code;
                     state_n     = HELD;
                  end else begin
                     state_n = PRESS_CHK;
                  end
               end
            end
            PRESS_CHK: begin
               if (res_key && (scan_code == cand)) begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt_n == CNT_W'(DEBOUNCE_SCANS)) begin
                     accept  = 1'b1;
                     state_n = HELD;
                  end
               end else begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
            HELD: begin
               // No rollover: anything but a clean NONE keeps us here.
               if (res_none) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     cnt_n   = '0;
                     state_n = IDLE;
                  end else begin
                     cnt_n   = CNT_W'(1);
                     state_n = RELEASE_CHK;
                  end
               end
            end
            default: begin // RELEASE_CHK
               if (res_none) begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt_n == CNT_W'(DEBOUNCE_SCANS)) begin
                     cnt_n   = '0;
                     state_n = IDLE;
                  end
               end else begin
                  state_n = HELD;
               end
            end
         endcase
      end
   end

   // Clear wins over the old contents but not over a digit accepted on the
   // same edge, which then lands in an otherwise empty register.
   always_comb begin
      key_code_n = key_code;
      value_n    = value;
      if (accept) begin
         key_code_n = accept_code;
         value_n    = clear ? {12'h000, accept_code} : {value[11:0], accept_code};
      end else if (clear) begin
         value_n = 16'h0000;
      end
   end

   assign key_down = (state == HELD) || (state == RELEASE_CHK);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_SCANS=2, using a keypad model that pulls a row low while the
// column of any pressed key on that row is driven low.
module tb_keypad_scanner;

   logic        clock;
   logic        reset;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        clear;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_down;
   logic [15:0] value;

   logic [15:0] pressed;   // bit r*4+c = key at row r, column c held
   int          checks;
   int          failures;
   int          pulses;

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .clear     (clear),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_down  (key_down),
      .value     (value)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   // key_valid is read before the edge updates it, so each high cycle
   // counts exactly once.
   always @(posedge clock) begin
      if (key_valid) pulses <= pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One scan = 16 cycles; all key changes happen on scan boundaries.
   task automatic hold(input logic [15:0] keys, input int scans);
      pressed = keys;
      repeat (16 * scans) @(negedge clock);
   endtask

   logic [3:0] col_seq [4];
   int         seq_idx [5];
   logic [3:0] seq_code [5];

   initial begin
      checks   = 0;
      failures = 0;
      pulses   = 0;
      pressed  = 16'h0000;
      clear    = 1'b0;
      reset    = 1'b1;
      col_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seq_idx  = '{0, 1, 2, 3, 7};
      seq_code = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_col", 32'(col), 32'(4'b1110));
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      check("rst_down", 32'(key_down), 32'd0);
      check("rst_value", 32'(value), 32'd0);
      reset = 1'b0;

      // Idle scanning: two full scans of column rotation
      for (int k = 1; k <= 32; k++) begin
         @(negedge clock);
         check("col_seq", 32'(col), 32'(col_seq[(k / 4) % 4]));
      end
      check("idle_pulses", 32'(pulses), 32'd0);
      check("idle_value", 32'(value), 32'd0);

      // '5' held 10 scans: accept on the edge ending the second scan
      hold(16'h0020, 1);
      check("k5_no_early", 32'(key_valid), 32'd0);
      hold(16'h0020, 1);
      check("k5_valid", 32'(key_valid), 32'd1);
      check("k5_down_rise", 32'(key_down), 32'd1);
      check("k5_code_now", 32'(key_code), 32'h5);
      @(negedge clock);
      check("k5_valid_1cyc", 32'(key_valid), 32'd0);
      repeat (15) @(negedge clock);
      hold(16'h0020, 7);
      check("k5_pulses", 32'(pulses), 32'd1);
      check("k5_code", 32'(key_code), 32'h5);
      check("k5_value", 32'(value), 32'h0005);
      check("k5_down_held", 32'(key_down), 32'd1);
      hold(16'h0000, 1);
      check("k5_down_rel1", 32'(key_down), 32'd1);
      hold(16'h0000, 1);
      check("k5_down_rel2", 32'(key_down), 32'd0);
      hold(16'h0000, 1);
      check("k5_pulses_after", 32'(pulses), 32'd1);

      // 1,2,3,A,B in turn
      for (int i = 0; i < 5; i++) begin
         hold(16'h0001 << seq_idx[i], 3);
         check("seq_code", 32'(key_code), 32'(seq_code[i]));
         hold(16'h0000, 3);
      end
      check("seq_pulses", 32'(pulses), 32'd6);
      check("seq_value", 32'(value), 32'h23AB);

      // '7' for a single scan: rejected
      hold(16'h0100, 1);
      hold(16'h0000, 3);
      check("k7_pulses", 32'(pulses), 32'd6);
      check("k7_down", 32'(key_down), 32'd0);
      check("k7_value", 32'(value), 32'h23AB);

      // '1'+'2' together (MULTI), then '1' alone
      hold(16'h0003, 4);
      check("multi_pulses", 32'(pulses), 32'd6);
      check("multi_down", 32'(key_down), 32'd0);
      hold(16'h0001, 1);
      check("multi_k1_one", 32'(key_valid), 32'd0);
      hold(16'h0001, 1);
      check("multi_k1_valid", 32'(key_valid), 32'd1);
      check("multi_k1_code", 32'(key_code), 32'h1);
      hold(16'h0001, 1);
      hold(16'h0000, 3);
      check("multi_pulses2", 32'(pulses), 32'd7);
      check("multi_value", 32'(value), 32'h3AB1);

      // Plain clear, then enter 1,2,3,4
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check("clear_value", 32'(value), 32'h0000);
      repeat (15) @(negedge clock);
      hold(16'h0001, 3); hold(16'h0000, 3);
      hold(16'h0002, 3); hold(16'h0000, 3);
      hold(16'h0004, 3); hold(16'h0000, 3);
      hold(16'h0010, 3); hold(16'h0000, 3);
      check("entry_value", 32'(value), 32'h1234);
      check("entry_pulses", 32'(pulses), 32'd11);

      // 'D' with clear coinciding with the accepting edge
      pressed = 16'h8000;
      repeat (16 + 15) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check("clrD_valid", 32'(key_valid), 32'd1);
      check("clrD_code", 32'(key_code), 32'hD);
      check("clrD_value", 32'(value), 32'h000D);
      hold(16'h8000, 1);
      hold(16'h0000, 3);
      check("clrD_pulses", 32'(pulses), 32'd12);

      // Reset during PRESS_CHK of 'E'
      hold(16'h4000, 1);
      repeat (5) @(negedge clock);
      reset   = 1'b1;
      pressed = 16'h0000;
      @(negedge clock);
      check("mrst_col", 32'(col), 32'(4'b1110));
      check("mrst_valid", 32'(key_valid), 32'd0);
      check("mrst_code", 32'(key_code), 32'd0);
      check("mrst_down", 32'(key_down), 32'd0);
      check("mrst_value", 32'(value), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("mrst_col0", 32'(col), 32'(4'b1110));
      @(negedge clock);
      check("mrst_col1", 32'(col), 32'(4'b1101));
      repeat (12) @(negedge clock);
      hold(16'h0000, 3);
      check("mrst_pulses", 32'(pulses), 32'd12);
      check("mrst_value_end", 32'(value), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Digilent Pmod KYPD) by driving one column low at a time and sampling the active-low rows. Debounces the result over whole scan cycles and emits one pulse per accepted key press. Accepted hex digits are shifted into a 16-bit entry register that feeds the calculator datapath and the seven-segment display.

## Interface
- SCAN_DIV, 2048: clock cycles each column is driven (one scan slot); >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release; >= 1.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- row  in  4  keypad rows, active-low, externally pulled up; row[0] top
- col  out  4  keypad columns, active-low, one-hot-low; col[0] leftmost
- clear  in  1  synchronous clear of value
- key_valid  out  1  one-cycle pulse per accepted press
- key_code  out  4  hex code of the last accepted key; held between pulses
- key_down  out  1  level, high while the accepted key is held (state HELD or RELEASE_CHK)
- value  out  16  entry register; newest digit in [3:0]

## Operation
- Key map (row, left->right): row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 0,F,E,D.
- Column sequence 4'b1110 -> 1101 -> 1011 -> 0111 -> 1110; each slot lasts SCAN_DIV cycles.
- row passes through a 2-flop synchronizer, reset to 4'b1111. The synchronized rows are sampled on the last cycle of each slot.
- Scan result is formed at the end of slot 3:
  - NONE: no low bits in any column.
  - KEY(k): exactly one row/column intersection is low.
  - MULTI: more than one intersection is low.
- FSM, evaluated once per scan end with a match counter cnt:
  - IDLE: KEY(k) -> cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately; else go to PRESS_CHK. NONE and MULTI stay in IDLE.
  - PRESS_CHK: KEY(cand) -> cnt+1; accept when cnt reaches DEBOUNCE_SCANS. Any other result -> IDLE.
  - Accept: key_valid=1 for one cycle, key_code=cand, value={value[11:0],cand}, go to HELD.
  - HELD: NONE -> cnt=1, RELEASE_CHK (IDLE directly if DEBOUNCE_SCANS==1). KEY or MULTI stays in HELD. No rollover: a second key is not accepted until full release.
  - RELEASE_CHK: NONE -> cnt+1; go to IDLE when cnt reaches DEBOUNCE_SCANS. KEY or MULTI -> HELD, with no new pulse.
- clear: value <= 0 on the next edge.
  - clear in the same cycle as an accept -> value = {12'h000, cand}.
- Reset values: col=4'b1110, key_valid=0, key_code=0, key_down=0, value=0, state IDLE, cnt=0, slot counter 0.
- Reset mid-scan or mid-debounce aborts everything: no pulse, and the scan restarts at column 0.

## Timing
- Scan period = 4*SCAN_DIV cycles. A column is driven for SCAN_DIV-2 cycles before its synchronized sample is taken.
- key_valid, key_code and value update on the clock edge that ends the deciding scan. key_valid is high for exactly the following cycle.
- Press latency from stable contact: between (DEBOUNCE_SCANS-1)*4*SCAN_DIV and (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- key_down rises with key_valid. It falls on the edge ending the DEBOUNCE_SCANS-th consecutive NONE scan.
- value width is exactly 16 bits. The oldest nibble is discarded on shift; there is no overflow flag.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=2. The keypad model pulls row[r] low while col[c] is low for each pressed key.
- Reset, no keys -> col cycles 1110,1101,1011,0111 every 4 cycles (period 16); key_valid never asserts; value=0x0000.
- Press '5' (row1, col1) held for 10 scans -> exactly one key_valid; key_code=4'h5; value=0x0005; key_down=1 until 2 scans after release.
- Press and release 1,2,3,A,B in turn, each held 3 scans and released 3 scans -> five pulses; value=0x23AB.
- Press '7' for 1 scan only, then release -> no key_valid; state returns to IDLE.
- Press '1' and '2' together for 4 scans (MULTI), then release '2' while holding '1' -> no pulse during MULTI; one pulse with code 1 after 2 KEY(1) scans.
- Assert clear in the key_valid cycle of 'D' with value=0x1234 -> value=0x000D. Then assert reset during PRESS_CHK of 'E' -> all outputs return to reset values and no pulse occurs.
